// File: rtl/register_bank.sv
// register_bank: small register file driven by a 3-bit op FSM (IDLE/EXEC/SWAP2).
// Latency: most ops complete one edge after acceptance, SWAP two; Done/Error pulse at completion.
// Backpressure: Busy is high while an op is in flight; Perform edges seen while busy are dropped.
//
// Ports:
//   Clock, Reset        - single clock, synchronous active-high reset
//   OP[2:0], K[KW-1:0]  - operation code and target index, latched on acceptance
//   Perform             - request strobe, only its rising edge starts an op
//   Regs                - all registers flattened, Rn at [n*WIDTH +: WIDTH]
//   Busy, Done, Error   - in-flight flag, completion pulse, illegal-index pulse
// Optional feature: define REGISTER_BANK_UNDO_EN for a one-deep undo shadow (OP 111 = undo).

module register_bank #(
    parameter int WIDTH = 5,
    parameter int NREGS = 4,
    parameter int KW    = 2
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [2:0]             OP,
    input  logic [KW-1:0]          K,
    input  logic                   Perform,
    output logic [NREGS*WIDTH-1:0] Regs,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Error
);

    localparam logic [2:0] OP_INIT   = 3'b000;
    localparam logic [2:0] OP_CLR0   = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_STORE  = 3'b011;
    localparam logic [2:0] OP_SWAP   = 3'b100;
    localparam logic [2:0] OP_CLRALL = 3'b101;
    localparam logic [2:0] OP_INC    = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SWAP2 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];
    logic [WIDTH-1:0]   temp_q, temp_d;
    logic [2:0]         op_q, op_d;
    logic [KW-1:0]      k_q, k_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               perform_prev_q;

`ifdef REGISTER_BANK_UNDO_EN
    logic               undo_vld_q, undo_vld_d;
    logic [KW-1:0]      undo_idx_q, undo_idx_d;
    logic [WIDTH-1:0]   undo_val_q, undo_val_d;
`endif

    // Current value of the register addressed by the latched K.
    logic [WIDTH-1:0]   rk;
    logic               uses_k;
    logic               k_bad;

    always_comb begin
        rk = '0;
        for (int n = 0; n < NREGS; n++) begin
            if (k_q == KW'(n)) begin
                rk = regs_q[n];
            end
        end
    end

    assign uses_k = (op_q == OP_LOAD) || (op_q == OP_STORE) ||
                    (op_q == OP_SWAP) || (op_q == OP_INC);
    // KW may address more slots than exist (e.g. NREGS=5, KW=3).
    assign k_bad  = int'(k_q) >= NREGS;

    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        temp_d  = temp_q;
        op_d    = op_q;
        k_d     = k_q;
        done_d  = 1'b0;
        error_d = 1'b0;
`ifdef REGISTER_BANK_UNDO_EN
        undo_vld_d = undo_vld_q;
        undo_idx_d = undo_idx_q;
        undo_val_d = undo_val_q;
`endif

        case (state_q)
            IDLE: begin
                // perform_prev_q comes out of reset high, so a held strobe is not a new request.
                if (Perform && !perform_prev_q) begin
                    op_d    = OP;
                    k_d     = K;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                state_d = IDLE;
                if (uses_k && k_bad) begin
                    error_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                    case (op_q)
                        OP_INIT: begin
                            for (int n = 0; n < NREGS; n++) begin
                                regs_d[n] = WIDTH'(n);
                            end
`ifdef REGISTER_BANK_UNDO_EN
                            undo_vld_d = 1'b0;
`endif
                        end
                        OP_CLR0: begin
                            regs_d[0] = '0;
                        end
                        OP_LOAD: begin
                            regs_d[0] = rk;
`ifdef REGISTER_BANK_UNDO_EN
                            undo_vld_d = 1'b1;
                            undo_idx_d = '0;
                            undo_val_d = regs_q[0];
`endif
                        end
                        OP_STORE: begin
                            for (int n = 0; n < NREGS; n++) begin
                                if (k_q == KW'(n)) begin
                                    regs_d[n] = regs_q[0];
                                end
                            end
`ifdef REGISTER_BANK_UNDO_EN
                            undo_vld_d = 1'b1;
                            undo_idx_d = k_q;
                            undo_val_d = rk;
`endif
                        end
                        OP_SWAP: begin
                            // First half: park RK, move R0 into RK; R0 gets temp next cycle.
                            temp_d = rk;
                            for (int n = 0; n < NREGS; n++) begin
                                if (k_q == KW'(n)) begin
                                    regs_d[n] = regs_q[0];
                                end
                            end
                            done_d  = 1'b0;
                            state_d = SWAP2;
                        end
                        OP_CLRALL: begin
                            for (int n = 0; n < NREGS; n++) begin
                                regs_d[n] = '0;
                            end
`ifdef REGISTER_BANK_UNDO_EN
                            undo_vld_d = 1'b0;
`endif
                        end
                        OP_INC: begin
                            for (int n = 0; n < NREGS; n++) begin
                                if (k_q == KW'(n)) begin
                                    regs_d[n] = rk + WIDTH'(1);
                                end
                            end
`ifdef REGISTER_BANK_UNDO_EN
                            undo_vld_d = 1'b1;
                            undo_idx_d = k_q;
                            undo_val_d = rk;
`endif
                        end
                        default: begin
`ifdef REGISTER_BANK_UNDO_EN
                            // OP 111: undo the last single-register write, if any.
                            if (undo_vld_q) begin
                                for (int n = 0; n < NREGS; n++) begin
                                    if (undo_idx_q == KW'(n)) begin
                                        regs_d[n] = undo_val_q;
                                    end
                                end
                            end
                            undo_vld_d = 1'b0;
`endif
                        end
                    endcase
                end
            end

            SWAP2: begin
                regs_d[0] = temp_q;
                done_d    = 1'b1;
                state_d   = IDLE;
`ifdef REGISTER_BANK_UNDO_EN
                undo_vld_d = 1'b1;
                undo_idx_d = '0;
                undo_val_d = regs_q[0];
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int n = 0; n < NREGS; n++) begin
                regs_q[n] <= WIDTH'(n);
            end
            temp_q         <= '0;
            state_q        <= IDLE;
            op_q           <= '0;
            k_q            <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            perform_prev_q <= 1'b1;
`ifdef REGISTER_BANK_UNDO_EN
            undo_vld_q     <= 1'b0;
            undo_idx_q     <= '0;
            undo_val_q     <= '0;
`endif
        end else begin
            regs_q         <= regs_d;
            temp_q         <= temp_d;
            state_q        <= state_d;
            op_q           <= op_d;
            k_q            <= k_d;
            done_q         <= done_d;
            error_q        <= error_d;
            perform_prev_q <= Perform;
`ifdef REGISTER_BANK_UNDO_EN
            undo_vld_q     <= undo_vld_d;
            undo_idx_q     <= undo_idx_d;
            undo_val_q     <= undo_val_d;
`endif
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
        assign Regs[g*WIDTH +: WIDTH] = regs_q[g];
    end

    assign Busy  = (state_q != IDLE);
    assign Done  = done_q;
    assign Error = error_q;

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

    localparam int W  = 5;
    localparam int NR = 5;
    localparam int KB = 3;
    localparam int MODV = 1 << W;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic [2:0]        OP = '0;
    logic [KB-1:0]     K = '0;
    logic              Perform = 1'b0;
    logic [NR*W-1:0]   Regs;
    logic              Busy, Done, Error;

    int total = 0;
    int bad   = 0;

    register_bank #(.WIDTH(W), .NREGS(NR), .KW(KB)) dut (
        .Clock(Clock), .Reset(Reset), .OP(OP), .K(K), .Perform(Perform),
        .Regs(Regs), .Busy(Busy), .Done(Done), .Error(Error)
    );

    always #5 Clock = ~Clock;

    // Behavioural model: plain integer array plus undo record.
    int mr [NR];
    bit sh_vld;
    int sh_idx, sh_val;

    function automatic void model_reset();
        for (int n = 0; n < NR; n++) mr[n] = n % MODV;
        sh_vld = 0;
    endfunction

    function automatic void rec(input int idx, input int val);
        sh_vld = 1; sh_idx = idx; sh_val = val;
    endfunction

    // Applies one op; returns cycles to completion and whether it is an error.
    function automatic void model_op(input int op, input int k, output int lat, output bit err);
        bit legal = (k < NR);
        int t;
        lat = 1; err = 0;
        if ((op == 2 || op == 3 || op == 4 || op == 6) && !legal) begin
            err = 1;
            return;
        end
        case (op)
            0: begin for (int n = 0; n < NR; n++) mr[n] = n % MODV; sh_vld = 0; end
            1: mr[0] = 0;
            2: begin rec(0, mr[0]); mr[0] = mr[k]; end
            3: begin rec(k, mr[k]); mr[k] = mr[0]; end
            4: begin lat = 2; t = mr[k]; mr[k] = mr[0]; rec(0, mr[0]); mr[0] = t; end
            5: begin for (int n = 0; n < NR; n++) mr[n] = 0; sh_vld = 0; end
            6: begin rec(k, mr[k]); mr[k] = (mr[k] + 1) % MODV; end
            default: begin
`ifdef REGISTER_BANK_UNDO_EN
                if (sh_vld) mr[sh_idx] = sh_val;
                sh_vld = 0;
`endif
            end
        endcase
    endfunction

    function automatic logic [NR*W-1:0] exp_regs();
        logic [NR*W-1:0] e;
        for (int n = 0; n < NR; n++) e[n*W +: W] = W'(mr[n]);
        return e;
    endfunction

    task automatic do_reset();
        @(negedge Clock); Reset = 1; Perform = 0;
        @(negedge Clock); @(negedge Clock); Reset = 0;
        model_reset();
    endtask

    // Pulse Perform for one edge; returns at the negedge after acceptance edge E.
    task automatic issue(input int op, input int k);
        @(negedge Clock); OP = 3'(op); K = KB'(k); Perform = 1;
        @(negedge Clock); Perform = 0;
    endtask

    task automatic test_reset();
        @(negedge Clock); Reset = 1; Perform = 1;
        @(negedge Clock); @(negedge Clock); Reset = 0;
        model_reset();
        repeat (3) @(negedge Clock);
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
        total++; if (Done !== 1'b0 || Error !== 1'b0) begin bad++; $display("FAIL reset_pulses done=%b err=%b want=0/0", Done, Error); end
        total++; if (Regs !== exp_regs()) begin bad++; $display("FAIL reset_regs got=%h want=%h", Regs, exp_regs()); end
        Perform = 0;
        @(negedge Clock);
        // Reset in the middle of a SWAP kills it without a pulse.
        issue(4, 3);
        @(negedge Clock); Reset = 1;
        @(negedge Clock); Reset = 0;
        model_reset();
        total++; if (Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0) begin bad++; $display("FAIL reset_mid busy=%b done=%b err=%b want=0/0/0", Busy, Done, Error); end
        total++; if (Regs !== exp_regs()) begin bad++; $display("FAIL reset_mid_regs got=%h want=%h", Regs, exp_regs()); end
    endtask

    task automatic test_store();
        int lat; bit err;
        do_reset();
        issue(3, 2);
        model_op(3, 2, lat, err);
        total++; if (Busy !== 1'b1 || Done !== 1'b0) begin bad++; $display("FAIL store_e busy=%b done=%b want=1/0", Busy, Done); end
        @(negedge Clock);
        total++; if (Done !== 1'b1 || Busy !== 1'b0) begin bad++; $display("FAIL store_done done=%b busy=%b want=1/0", Done, Busy); end
        total++; if (Regs[2*W +: W] !== W'(0) || Regs !== exp_regs()) begin bad++; $display("FAIL store_regs got=%h want=%h", Regs, exp_regs()); end
    endtask

    task automatic test_swap();
        int lat; bit err;
        do_reset();
        issue(4, 3);
        model_op(4, 3, lat, err);
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL swap_busy_e got=%b want=1", Busy); end
        @(negedge Clock);
        total++; if (Regs[3*W +: W] !== W'(0) || Regs[0 +: W] !== W'(0) || Busy !== 1'b1 || Done !== 1'b0)
            begin bad++; $display("FAIL swap_mid r3=%0d r0=%0d busy=%b done=%b want 0/0/1/0", Regs[3*W +: W], Regs[0 +: W], Busy, Done); end
        @(negedge Clock);
        total++; if (Regs[0 +: W] !== W'(3) || Done !== 1'b1 || Busy !== 1'b0)
            begin bad++; $display("FAIL swap_end r0=%0d done=%b busy=%b want 3/1/0", Regs[0 +: W], Done, Busy); end
        total++; if (Regs !== exp_regs()) begin bad++; $display("FAIL swap_regs got=%h want=%h", Regs, exp_regs()); end
        @(negedge Clock);
        total++; if (Done !== 1'b0) begin bad++; $display("FAIL swap_done_width got=%b want=0", Done); end
    endtask

    task automatic test_inc_wrap();
        int lat; bit err;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            issue(6, 1); model_op(6, 1, lat, err);
            @(negedge Clock);
        end
        total++; if (Regs[W +: W] !== W'(31)) begin bad++; $display("FAIL inc_setup r1=%0d want=31", Regs[W +: W]); end
        issue(6, 1); model_op(6, 1, lat, err);
        @(negedge Clock);
        total++; if (Regs[W +: W] !== W'(0) || Regs !== exp_regs() || Done !== 1'b1)
            begin bad++; $display("FAIL inc_wrap got=%h done=%b want=%h done=1", Regs, Done, exp_regs()); end
    endtask

    task automatic test_ignore();
        int lat; bit err; int dones;
        // Strobe held high across three edges: one op.
        do_reset();
        @(negedge Clock); OP = 3'd1; K = '0; Perform = 1;
        model_op(1, 0, lat, err);
        dones = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge Clock);
            if (i == 2) Perform = 0;
            if (Done === 1'b1) dones++;
        end
        total++; if (dones != 1 || Regs !== exp_regs()) begin bad++; $display("FAIL hold_one dones=%0d want=1 regs=%h want=%h", dones, Regs, exp_regs()); end
        // Second rising edge during a SWAP: dropped, not queued.
        issue(4, 2); model_op(4, 2, lat, err);
        Perform = 1;
        dones = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge Clock);
            if (Done === 1'b1) dones++;
        end
        Perform = 0;
        @(negedge Clock); @(negedge Clock);
        total++; if (dones != 1 || Busy !== 1'b0 || Regs !== exp_regs())
            begin bad++; $display("FAIL busy_edge dones=%0d busy=%b want 1/0 regs=%h want=%h", dones, Busy, Regs, exp_regs()); end
    endtask

    task automatic test_illegal();
        int lat; bit err;
        do_reset();
        issue(2, 6); model_op(2, 6, lat, err);
        @(negedge Clock);
        total++; if (Error !== 1'b1 || Done !== 1'b0 || Busy !== 1'b0)
            begin bad++; $display("FAIL illegal err=%b done=%b busy=%b want 1/0/0", Error, Done, Busy); end
        total++; if (Regs !== exp_regs()) begin bad++; $display("FAIL illegal_regs got=%h want=%h", Regs, exp_regs()); end
        @(negedge Clock);
        total++; if (Error !== 1'b0) begin bad++; $display("FAIL illegal_pulse got=%b want=0", Error); end
    endtask

    task automatic test_op7();
        int lat; bit err;
        do_reset();
        issue(3, 1); model_op(3, 1, lat, err); @(negedge Clock);
        issue(7, 0); model_op(7, 0, lat, err); @(negedge Clock);
        total++; if (Done !== 1'b1 || Regs !== exp_regs()) begin bad++; $display("FAIL op7_first done=%b regs=%h want 1 %h", Done, Regs, exp_regs()); end
`ifdef REGISTER_BANK_UNDO_EN
        total++; if (Regs[W +: W] !== W'(1)) begin bad++; $display("FAIL undo_r1 got=%0d want=1", Regs[W +: W]); end
`else
        total++; if (Regs[W +: W] !== W'(0)) begin bad++; $display("FAIL nop_r1 got=%0d want=0", Regs[W +: W]); end
`endif
        issue(7, 0); model_op(7, 0, lat, err); @(negedge Clock);
        total++; if (Done !== 1'b1 || Regs !== exp_regs()) begin bad++; $display("FAIL op7_second done=%b regs=%h want 1 %h", Done, Regs, exp_regs()); end
    endtask

    task automatic test_random();
        int lat, op, k, cyc; bit err; bit sd, se;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(7); k = $urandom_range(7);
            issue(op, k); model_op(op, k, lat, err);
            cyc = 0; sd = 0; se = 0;
            for (int c = 1; c <= 4; c++) begin
                @(negedge Clock);
                cyc = c;
                if (Done === 1'b1) sd = 1;
                if (Error === 1'b1) se = 1;
                if (Busy !== 1'b1) break;
            end
            total++;
            if (cyc != lat || sd != !err || se != err || Regs !== exp_regs()) begin
                bad++;
                $display("FAIL rand op=%0d k=%0d lat=%0d/%0d done=%b err=%b want err=%b regs=%h want=%h",
                         op, k, cyc, lat, sd, se, err, Regs, exp_regs());
            end
            repeat ($urandom_range(1)) @(negedge Clock);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_swap();
        test_inc_wrap();
        test_ignore();
        test_illegal();
        test_op7();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 5: bit width of each register.
REQ-002 Parameter NREGS, default 4, legal range 2..16: number of registers R0..R(NREGS-1).
REQ-003 Parameter KW, default 2: width of K; the instantiator SHALL set KW = ceil(log2(NREGS)).
REQ-004 Port Clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1: synchronous, active-high reset, sampled on the Clock rising edge.
REQ-006 Port OP, input, 3: operation code, captured only when a request is accepted.
REQ-007 Port K, input, KW: target register index, captured with OP.
REQ-008 Port Perform, input, 1: request strobe; accepted on its rising edge only.
REQ-009 Port Regs, output, NREGS*WIDTH: all registers flattened; Rn occupies bits [n*WIDTH +: WIDTH].
REQ-010 Port Busy, output, 1: high from acceptance until the operation completes.
REQ-011 Port Done, output, 1: one-cycle pulse, high in the cycle in which the final register values are first visible.
REQ-012 Port Error, output, 1: one-cycle pulse for an illegal K; asserted in place of Done.

Function
REQ-013 Acceptance SHALL occur at a Clock edge where Perform=1, the registered previous Perform=0, and state=IDLE; OP and K are latched, and Busy=1 after that edge (edge E).
REQ-014 A Perform rising edge while Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-015 The FSM SHALL have states IDLE, EXEC, SWAP2 and no others; EXEC follows acceptance; EXEC goes to IDLE, or to SWAP2 for SWAP; SWAP2 always goes to IDLE.
REQ-016 OP 000 INIT SHALL set Rn = n mod 2^WIDTH for every n at edge E+1.
REQ-017 OP 001 CLR0 SHALL set R0 = 0 at edge E+1.
REQ-018 OP 010 LOAD SHALL set R0 = RK at edge E+1; K=0 leaves R0 unchanged.
REQ-019 OP 011 STORE SHALL set RK = R0 at edge E+1; K=0 leaves R0 unchanged.
REQ-020 OP 100 SWAP: at edge E+1, temp = RK and RK = R0; at edge E+2, R0 = temp; K=0 leaves R0 unchanged and still takes 2 cycles.
REQ-021 OP 101 CLRALL SHALL zero all registers at edge E+1.
REQ-022 OP 110 INC SHALL set RK = RK + 1 modulo 2^WIDTH at edge E+1, so all-ones wraps to 0.
REQ-023 OP 111 SHALL be a NOP completing at edge E+1 with Done, unless REQ-030 applies.
REQ-024 For OPs LOAD, STORE, SWAP and INC with K >= NREGS, no register SHALL change, Error SHALL pulse at edge E+1, Done SHALL stay low, and the FSM SHALL return to IDLE.
REQ-025 Busy SHALL fall and Done SHALL rise at the completing edge: E+1 for single-cycle ops, E+2 for SWAP; the earliest next acceptance is the completing edge +1.
REQ-026 Registers SHALL hold their values whenever no operation writes them; Regs SHALL be driven directly from the storage flops, with no combinational path from OP or K.

Reset
REQ-027 When Reset=1 at an edge, the block SHALL set Rn = n mod 2^WIDTH, temp = 0, state = IDLE, Busy = 0, Done = 0, Error = 0, and the previous-Perform register = 1, so that a Perform already held high is not accepted.
REQ-028 Reset SHALL take priority over every operation, including one in EXEC or SWAP2; an interrupted operation produces no Done or Error pulse.

Configuration
REQ-029 Macro REGISTER_BANK_UNDO_EN SHALL compile in a one-deep undo shadow holding the index and old value of the most recently written single register (LOAD, STORE, INC, or the final R0 write of SWAP); INIT, CLRALL and Reset invalidate the shadow.
REQ-030 With REGISTER_BANK_UNDO_EN defined, OP 111 SHALL restore the shadowed register at edge E+1 and then invalidate the shadow; with no valid shadow it behaves as a NOP; Done pulses in both cases.
REQ-031 Without REGISTER_BANK_UNDO_EN, no shadow logic SHALL exist and OP 111 is always a NOP.

Verification
REQ-032 Reset, then OP=011, K=2, Perform pulse: R2 = 0 at E+1, Done=1 at E+1, Busy=0 at E+1, R0/R1/R3 = 0/1/3.
REQ-033 After reset, OP=100, K=3: at E+1 R3 = 0 and R0 = 0; at E+2 R0 = 3 and Done=1; Busy is high for exactly 2 cycles.
REQ-034 Set R1 = 31 (WIDTH=5), then OP=110, K=1: R1 = 0 at E+1, with no other register changed.
REQ-035 Hold Perform high across 3 edges, and issue a second rising edge while Busy=1: exactly one operation is accepted and exactly one Done pulse is produced.
REQ-036 NREGS=5, KW=3, OP=010, K=6: Error pulses at E+1, Done stays 0, and all registers are unchanged.
REQ-037 With REGISTER_BANK_UNDO_EN: STORE K=1 (R1 1->0), then OP=111: R1 = 1 and Done=1; a second OP=111 leaves registers unchanged.
